// File: rtl/regfile_wb_queue_if.sv
// Bundle between the execute/memory producers, the register-file write port
// and the decode-stage forwarding lookup of the write-back queue.
interface regfile_wb_queue_if #(
  parameter int XLEN = 64,
  parameter int REGW = 6
);
  // Load-unit result channel
  logic            ld_valid;
  logic [REGW-1:0] ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            ld_ready;

  // ALU result channel
  logic            alu_valid;
  logic [REGW-1:0] alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  // Register file write port
  logic            RegWrite;
  logic [REGW-1:0] WriteReg;
  logic [XLEN-1:0] WriteData;

  // Forwarding lookup
  logic [REGW-1:0] q_rs1;
  logic [REGW-1:0] q_rs2;
  logic            q_hit1;
  logic [XLEN-1:0] q_data1;
  logic            q_hit2;
  logic [XLEN-1:0] q_data2;

  // Queue side: consumes producer results and lookup indices, drives the write port
  modport slave (
    input  ld_valid, ld_rd, ld_data,
    output ld_ready,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    output RegWrite, WriteReg, WriteData,
    input  q_rs1, q_rs2,
    output q_hit1, q_data1, q_hit2, q_data2
  );

  // Environment side: producers, register file and decode
  modport master (
    output ld_valid, ld_rd, ld_data,
    input  ld_ready,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    input  RegWrite, WriteReg, WriteData,
    output q_rs1, q_rs2,
    input  q_hit1, q_data1, q_hit2, q_data2
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// Write-back queue: gathers load and ALU results in order, drains one per
// cycle onto the register file write port, drops x0 destinations and offers
// a youngest-match forwarding lookup over the entries still in flight.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64,
  parameter int REGW  = 6
) (
  input  logic clk,
  input  logic reset,
  regfile_wb_queue_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  // Advance a pointer by k slots, wrapping modulo DEPTH (k never exceeds DEPTH-1)
  function automatic ptr_t ptr_add(input ptr_t p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return ptr_t'(s);
  endfunction

  // Control state
  ptr_t head_q, head_d;
  ptr_t tail_q, tail_d;
  cnt_t count_q, count_d;

  // Entry storage; validity is implied by head/count, so it needs no reset
  logic [REGW-1:0] rd_q   [DEPTH];
  logic [REGW-1:0] rd_d   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [XLEN-1:0] data_d [DEPTH];

  logic       ld_rdy, alu_rdy;
  logic       ld_push, alu_push;
  logic       pop;
  logic [1:0] push_cnt;
  ptr_t       alu_slot;

  // Ready depends only on the registered occupancy; the ALU needs room for a
  // possible simultaneous load, hence its threshold is one entry lower
  always_comb begin
    ld_rdy   = (count_q <= cnt_t'(DEPTH - 1));
    alu_rdy  = (count_q <= cnt_t'(DEPTH - 2));
    ld_push  = bus.ld_valid  & ld_rdy  & (bus.ld_rd  != '0);
    alu_push = bus.alu_valid & alu_rdy & (bus.alu_rd != '0);
    push_cnt = {1'b0, ld_push} + {1'b0, alu_push};
    pop      = (count_q != '0);
  end

  assign bus.ld_ready  = ld_rdy;
  assign bus.alu_ready = alu_rdy;

  // Next-state: load lands at tail, ALU behind it when both arrive together
  always_comb begin
    rd_d   = rd_q;
    data_d = data_q;
    alu_slot = ld_push ? ptr_add(tail_q, 1) : tail_q;
    if (ld_push) begin
      rd_d[tail_q]   = bus.ld_rd;
      data_d[tail_q] = bus.ld_data;
    end
    if (alu_push) begin
      rd_d[alu_slot]   = bus.alu_rd;
      data_d[alu_slot] = bus.alu_data;
    end
    tail_d  = ptr_add(tail_q, int'(push_cnt));
    head_d  = ptr_add(head_q, pop ? 1 : 0);
    count_d = count_q + cnt_t'(push_cnt) - cnt_t'(pop);
  end

  // Pointer and occupancy registers; reset discards everything queued
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload registers
  always_ff @(posedge clk) begin
    rd_q   <= rd_d;
    data_q <= data_d;
  end

  // Write port presents the head entry whenever the queue is non-empty
  always_comb begin
    bus.RegWrite  = pop;
    bus.WriteReg  = pop ? rd_q[head_q]   : '0;
    bus.WriteData = pop ? data_q[head_q] : '0;
  end

  // Forwarding: walk oldest to youngest so the last match (youngest) wins;
  // entries being offered this cycle are not yet visible
  always_comb begin
    ptr_t idx;
    bus.q_hit1  = 1'b0;
    bus.q_data1 = '0;
    bus.q_hit2  = 1'b0;
    bus.q_data2 = '0;
    idx = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      idx = ptr_add(head_q, k);
      if (k < int'(count_q)) begin
        if ((bus.q_rs1 != '0) && (rd_q[idx] == bus.q_rs1)) begin
          bus.q_hit1  = 1'b1;
          bus.q_data1 = data_q[idx];
        end
        if ((bus.q_rs2 != '0) && (rd_q[idx] == bus.q_rs2)) begin
          bus.q_hit2  = 1'b1;
          bus.q_data2 = data_q[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for the write-back queue: a scoreboard queue of pending writes is
// filled when producer transfers are accepted and drained as the DUT writes.
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;
  localparam int REGW  = 6;

  typedef struct packed {
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  int   compared   = 0;
  int   mismatched = 0;
  ent_t sb[$];

  regfile_wb_queue_if #(.XLEN(XLEN), .REGW(REGW)) bus ();

  regfile_wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .REGW(REGW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Youngest pending data for rs: {hit, data}
  function automatic logic [XLEN:0] model_fwd(input logic [REGW-1:0] rs);
    logic [XLEN:0] r;
    r = '0;
    if (rs != '0)
      foreach (sb[i])
        if (sb[i].rd == rs) r = {1'b1, sb[i].data};
    return r;
  endfunction

  // One clock of scoreboard: check outputs at negedge against the model,
  // then advance the model across the posedge
  task automatic step();
    logic          exp_we, exp_ldr, exp_alur, ld_acc, alu_acc;
    logic [REGW-1:0] exp_reg;
    logic [XLEN-1:0] exp_dat;
    logic [XLEN:0] f1, f2;
    @(negedge clk);
    exp_we   = (sb.size() != 0);
    exp_reg  = exp_we ? sb[0].rd   : '0;
    exp_dat  = exp_we ? sb[0].data : '0;
    exp_ldr  = (sb.size() <= DEPTH - 1);
    exp_alur = (sb.size() <= DEPTH - 2);
    f1 = model_fwd(bus.q_rs1);
    f2 = model_fwd(bus.q_rs2);
    compared++;
    if (bus.RegWrite !== exp_we) begin
      mismatched++; $display("FAIL sb_regwrite: got %0b want %0b", bus.RegWrite, exp_we);
    end
    compared++;
    if (bus.WriteReg !== exp_reg) begin
      mismatched++; $display("FAIL sb_writereg: got %0d want %0d", bus.WriteReg, exp_reg);
    end
    compared++;
    if (bus.WriteData !== exp_dat) begin
      mismatched++; $display("FAIL sb_writedata: got %0h want %0h", bus.WriteData, exp_dat);
    end
    compared++;
    if (bus.ld_ready !== exp_ldr) begin
      mismatched++; $display("FAIL sb_ld_ready: got %0b want %0b", bus.ld_ready, exp_ldr);
    end
    compared++;
    if (bus.alu_ready !== exp_alur) begin
      mismatched++; $display("FAIL sb_alu_ready: got %0b want %0b", bus.alu_ready, exp_alur);
    end
    compared++;
    if ({bus.q_hit1, bus.q_data1} !== f1) begin
      mismatched++; $display("FAIL sb_fwd1: got %0h want %0h", {bus.q_hit1, bus.q_data1}, f1);
    end
    compared++;
    if ({bus.q_hit2, bus.q_data2} !== f2) begin
      mismatched++; $display("FAIL sb_fwd2: got %0h want %0h", {bus.q_hit2, bus.q_data2}, f2);
    end
    ld_acc  = bus.ld_valid  && exp_ldr;
    alu_acc = bus.alu_valid && exp_alur;
    @(posedge clk);
    if (reset) begin
      sb.delete();
    end else begin
      if (sb.size() != 0) void'(sb.pop_front());
      if (ld_acc  && bus.ld_rd  != '0) sb.push_back({bus.ld_rd,  bus.ld_data});
      if (alu_acc && bus.alu_rd != '0) sb.push_back({bus.alu_rd, bus.alu_data});
    end
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_valid  = 1'b0;
    bus.alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.q_rs1 = 6'd5;
    bus.q_rs2 = 6'd9;
    compared++;
    if (bus.RegWrite !== 1'b0) begin
      mismatched++; $display("FAIL reset_regwrite: got %0b want 0", bus.RegWrite);
    end
    compared++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      mismatched++; $display("FAIL reset_ready: got %0b%0b want 11", bus.ld_ready, bus.alu_ready);
    end
    compared++;
    if (bus.q_hit1 !== 1'b0 || bus.q_hit2 !== 1'b0 || bus.q_data1 !== '0) begin
      mismatched++; $display("FAIL reset_hits: got %0b%0b want 00", bus.q_hit1, bus.q_hit2);
    end
    step();
  endtask

  task automatic test_single_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd5; bus.alu_data = 64'hDEAD;
    step();
    idle_inputs();
    compared++;
    if (bus.RegWrite !== 1'b1 || bus.WriteReg !== 6'd5 || bus.WriteData !== 64'hDEAD) begin
      mismatched++;
      $display("FAIL single_write: got we=%0b reg=%0d data=%0h want 1/5/dead",
               bus.RegWrite, bus.WriteReg, bus.WriteData);
    end
    step();
    compared++;
    if (bus.RegWrite !== 1'b0) begin
      mismatched++; $display("FAIL single_once: got %0b want 0", bus.RegWrite);
    end
  endtask

  task automatic test_dual_push();
    bus.ld_valid  = 1'b1; bus.ld_rd  = 6'd3; bus.ld_data  = 64'h11;
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd4; bus.alu_data = 64'h22;
    step();
    idle_inputs();
    compared++;
    if (bus.WriteReg !== 6'd3 || bus.WriteData !== 64'h11) begin
      mismatched++; $display("FAIL dual_first: got %0d/%0h want 3/11", bus.WriteReg, bus.WriteData);
    end
    step();
    compared++;
    if (bus.WriteReg !== 6'd4 || bus.WriteData !== 64'h22 || bus.RegWrite !== 1'b1) begin
      mismatched++; $display("FAIL dual_second: got %0d/%0h want 4/22", bus.WriteReg, bus.WriteData);
    end
    step();
  endtask

  task automatic test_x0();
    bus.q_rs1 = 6'd0;
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd0; bus.alu_data = 64'hFFFF;
    compared++;
    if (bus.alu_ready !== 1'b1) begin
      mismatched++; $display("FAIL x0_accept: got %0b want 1", bus.alu_ready);
    end
    step();
    idle_inputs();
    compared++;
    if (bus.RegWrite !== 1'b0 || bus.q_hit1 !== 1'b0) begin
      mismatched++; $display("FAIL x0_suppress: got we=%0b hit=%0b want 0/0", bus.RegWrite, bus.q_hit1);
    end
    step();
  endtask

  task automatic test_fill_and_reset();
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid  = 1'b1; bus.ld_rd  = REGW'(8 + i);  bus.ld_data  = 64'h100 + 64'(i);
      bus.alu_valid = 1'b1; bus.alu_rd = REGW'(16 + i); bus.alu_data = 64'h200 + 64'(i);
      step();
      if (i == 1) begin
        compared++;
        if (bus.alu_ready !== 1'b0 || bus.ld_ready !== 1'b1) begin
          mismatched++;
          $display("FAIL fill_ready: got ld=%0b alu=%0b want 1/0", bus.ld_ready, bus.alu_ready);
        end
      end
    end
    idle_inputs();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    compared++;
    if (bus.RegWrite !== 1'b0 || bus.WriteReg !== '0) begin
      mismatched++; $display("FAIL midreset_flush: got we=%0b reg=%0d want 0/0", bus.RegWrite, bus.WriteReg);
    end
    compared++;
    if (bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin
      mismatched++; $display("FAIL midreset_ready: got %0b%0b want 11", bus.ld_ready, bus.alu_ready);
    end
    step();
  endtask

  task automatic test_forward();
    bus.q_rs1 = 6'd7; bus.q_rs2 = 6'd7;
    bus.ld_valid  = 1'b1; bus.ld_rd  = 6'd7; bus.ld_data  = 64'hA;
    bus.alu_valid = 1'b1; bus.alu_rd = 6'd7; bus.alu_data = 64'hB;
    step();
    idle_inputs();
    compared++;
    if (bus.q_hit2 !== 1'b1 || bus.q_data2 !== 64'hB) begin
      mismatched++; $display("FAIL fwd_youngest: got %0b/%0h want 1/b", bus.q_hit2, bus.q_data2);
    end
    step();
    compared++;
    if (bus.q_hit2 !== 1'b1 || bus.q_data2 !== 64'hB) begin
      mismatched++; $display("FAIL fwd_remaining: got %0b/%0h want 1/b", bus.q_hit2, bus.q_data2);
    end
    step();
    compared++;
    if (bus.q_hit2 !== 1'b0 || bus.q_data2 !== '0) begin
      mismatched++; $display("FAIL fwd_drained: got %0b/%0h want 0/0", bus.q_hit2, bus.q_data2);
    end
  endtask

  task automatic test_back_to_back();
    int guard;
    for (int i = 0; i < 80; i++) begin
      bus.ld_valid  = 1'($urandom_range(0, 1));
      bus.ld_rd     = REGW'($urandom_range(0, 7));
      bus.ld_data   = {$urandom, $urandom};
      bus.alu_valid = 1'($urandom_range(0, 1));
      bus.alu_rd    = REGW'($urandom_range(0, 7));
      bus.alu_data  = {$urandom, $urandom};
      bus.q_rs1     = REGW'($urandom_range(0, 7));
      bus.q_rs2     = REGW'($urandom_range(0, 7));
      step();
    end
    idle_inputs();
    guard = 0;
    while (sb.size() != 0 && guard < 3 * DEPTH) begin
      step();
      guard++;
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("FAIL b2b_drain_timeout: got %0d pending want 0", sb.size());
    end
    step();
  endtask

  initial begin
    reset = 1'b1;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.q_rs1 = '0; bus.q_rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_single_alu();
    test_dual_push();
    test_x0();
    test_fill_and_reset();
    test_forward();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
